// File: rtl/score_digit_sequencer.sv
// -----------------------------------------------------------------------------
// score_digit_sequencer
//
// Purpose:
//   Upstream feeder for the digit sprite renderer. A binary game counter is
//   accepted over a valid/ready handshake and saturated to the largest value
//   that fits in NUM_DIGITS decimal digits. A double-dabble FSM then converts
//   it to BCD at one shift per cycle. The result is committed to the displayed
//   register only during vertical blank (DrawY >= 480), so no frame ever shows
//   a half-updated value. For every pixel the block emits, one cycle later,
//   the BCD digit under the pixel and the pixel's offset inside that glyph.
//
// Configuration macro:
//   LEADING_ZERO_BLANK_EN - when defined, leading zero digits (never the least
//                           significant one) drive digit_active = 0. The digit
//                           and glyph coordinates are still driven.
//
// Ports:
//   vga_clk      in   1        pixel clock (only clock)
//   reset_n      in   1        synchronous active-low reset
//   value_in     in   VALUE_W  binary value to display
//   value_valid  in   1        value_in is valid
//   value_ready  out  1        block accepts a value this cycle (state IDLE)
//   busy         out  1        conversion or pending commit in progress
//   DrawX        in   10       current pixel X
//   DrawY        in   10       current pixel Y
//   digit_out    out  4        BCD digit for the pixel (registered)
//   glyph_x      out  6        X offset inside the glyph (registered)
//   glyph_y      out  6        Y offset inside the glyph (registered)
//   digit_active out  1        pixel lies inside a drawn glyph (registered)
// -----------------------------------------------------------------------------
module score_digit_sequencer #(
    parameter int         NUM_DIGITS = 4,
    parameter int         VALUE_W    = 14,
    parameter logic [9:0] ORIGIN_X   = 10'd560,
    parameter logic [9:0] ORIGIN_Y   = 10'd8,
    parameter int         GLYPH_W    = 45,
    parameter int         GLYPH_H    = 60
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [VALUE_W-1:0] value_in,
    input  logic               value_valid,
    output logic               value_ready,
    output logic               busy,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    output logic [3:0]         digit_out,
    output logic [5:0]         glyph_x,
    output logic [5:0]         glyph_y,
    output logic               digit_active
);

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int k = 0; k < n; k++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam int          BCD_W     = 4 * NUM_DIGITS;
    localparam int          WORK_W    = BCD_W + VALUE_W;
    localparam int          CNT_W     = $clog2(VALUE_W + 1);
    localparam int          IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [31:0] MAX_VAL   = 32'(pow10(NUM_DIGITS) - 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(VALUE_W - 1);
    localparam logic [10:0] X_BEGIN   = {1'b0, ORIGIN_X};
    localparam logic [10:0] Y_BEGIN   = {1'b0, ORIGIN_Y};
    localparam logic [10:0] X_END     = 11'(int'(ORIGIN_X) + NUM_DIGITS * GLYPH_W);
    localparam logic [10:0] Y_END     = 11'(int'(ORIGIN_Y) + GLYPH_H);
    localparam logic [9:0]  VBLANK_Y  = 10'd480;

    // One double-dabble step: correct every BCD nibble >= 5 by +3, then
    // shift the whole {bcd, bin} register left by one.
    function automatic logic [WORK_W-1:0] dd_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] t;
        t = w;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (t[VALUE_W + 4*d +: 4] >= 4'd5) begin
                t[VALUE_W + 4*d +: 4] = t[VALUE_W + 4*d +: 4] + 4'd3;
            end else begin
                t[VALUE_W + 4*d +: 4] = t[VALUE_W + 4*d +: 4];
            end
        end
        return {t[WORK_W-2:0], 1'b0};
    endfunction

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_PEND    = 2'd2
    } state_e;

    state_e              state_q;
    logic [WORK_W-1:0]   work_q;
    logic [CNT_W-1:0]    step_q;
    logic [BCD_W-1:0]    disp_bcd_q;
    logic [VALUE_W-1:0]  value_sat_s;

    // Clamp the incoming value to the largest NUM_DIGITS-digit decimal.
    always_comb begin
        if (32'(value_in) > MAX_VAL) begin
            value_sat_s = VALUE_W'(MAX_VAL);
        end else begin
            value_sat_s = value_in;
        end
    end

    // Conversion FSM: accept, VALUE_W dabble steps, then commit in vblank.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            work_q     <= '0;
            step_q     <= '0;
            disp_bcd_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (value_valid) begin
                        work_q  <= {{BCD_W{1'b0}}, value_sat_s};
                        step_q  <= '0;
                        state_q <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    work_q <= dd_step(work_q);
                    if (step_q == LAST_STEP) begin
                        step_q  <= '0;
                        state_q <= S_PEND;
                    end else begin
                        step_q  <= step_q + CNT_W'(1);
                    end
                end
                S_PEND: begin
                    // Only the first vblank cycle reaches here with PEND, so
                    // the copy happens exactly once per conversion.
                    if (DrawY >= VBLANK_Y) begin
                        disp_bcd_q <= work_q[WORK_W-1 -: BCD_W];
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign value_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);

    // ---------------------------------------------------------------------
    // Pixel path
    // ---------------------------------------------------------------------
    logic [9:0]       rel_x_s;
    logic             in_x_s;
    logic             in_y_s;
    logic [IDX_W-1:0] digit_idx_s;
    logic [5:0]       gx_s;
    logic [5:0]       gy_s;
    logic [3:0]       nibble_s;
`ifdef LEADING_ZERO_BLANK_EN
    logic             lz_chain_s;
    logic             blank_s;
`endif

    logic [3:0] digit_d, digit_q;
    logic [5:0] gx_d, gx_q;
    logic [5:0] gy_d, gy_q;
    logic       act_d, act_q;

    // Locate the glyph under the pixel with constant comparators at k*GLYPH_W
    // (no divider) and pick its nibble from the displayed register only.
    always_comb begin
        rel_x_s     = DrawX - ORIGIN_X;
        in_x_s      = ({1'b0, DrawX} >= X_BEGIN) && ({1'b0, DrawX} < X_END);
        in_y_s      = ({1'b0, DrawY} >= Y_BEGIN) && ({1'b0, DrawY} < Y_END);
        gy_s        = 6'(DrawY - ORIGIN_Y);
        digit_idx_s = '0;
        gx_s        = 6'(rel_x_s);
        for (int k = 1; k < NUM_DIGITS; k++) begin
            digit_idx_s = (rel_x_s >= 10'(k * GLYPH_W)) ? IDX_W'(k) : digit_idx_s;
            gx_s        = (rel_x_s >= 10'(k * GLYPH_W)) ? 6'(rel_x_s - 10'(k * GLYPH_W)) : gx_s;
        end
        nibble_s = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            nibble_s = (digit_idx_s == IDX_W'(d)) ? disp_bcd_q[(NUM_DIGITS-1-d)*4 +: 4] : nibble_s;
        end
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every more significant digit
        // are zero; the least significant digit is always drawn.
        lz_chain_s = 1'b1;
        blank_s    = 1'b0;
        for (int d = 0; d < NUM_DIGITS - 1; d++) begin
            lz_chain_s = lz_chain_s && (disp_bcd_q[(NUM_DIGITS-1-d)*4 +: 4] == 4'd0);
            blank_s    = (digit_idx_s == IDX_W'(d)) ? lz_chain_s : blank_s;
        end
`endif
    end

    // Next-state of the registered pixel outputs; all zero outside the glyphs.
    always_comb begin
        if (in_x_s && in_y_s) begin
            digit_d = nibble_s;
            gx_d    = gx_s;
            gy_d    = gy_s;
`ifdef LEADING_ZERO_BLANK_EN
            act_d   = !blank_s;
`else
            act_d   = 1'b1;
`endif
        end else begin
            digit_d = 4'd0;
            gx_d    = 6'd0;
            gy_d    = 6'd0;
            act_d   = 1'b0;
        end
    end

    // One-cycle pixel pipeline register feeding the renderer's ROM read.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            digit_q <= 4'd0;
            gx_q    <= 6'd0;
            gy_q    <= 6'd0;
            act_q   <= 1'b0;
        end else begin
            digit_q <= digit_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            act_q   <= act_d;
        end
    end

    assign digit_out    = digit_q;
    assign glyph_x      = gx_q;
    assign glyph_y      = gy_q;
    assign digit_active = act_q;

endmodule

// File: tb/tb_score_digit_sequencer.sv
module tb_score_digit_sequencer;

    localparam int ND = 4;
    localparam int VW = 14;
    localparam int OX = 560;
    localparam int OY = 8;
    localparam int GW = 45;
    localparam int GH = 60;

    logic          vga_clk = 1'b0;
    logic          reset_n;
    logic [VW-1:0] value_in;
    logic          value_valid;
    logic          value_ready;
    logic          busy;
    logic [9:0]    DrawX;
    logic [9:0]    DrawY;
    logic [3:0]    digit_out;
    logic [5:0]    glyph_x;
    logic [5:0]    glyph_y;
    logic          digit_active;

    int n_checks = 0;
    int n_errors = 0;

    score_digit_sequencer dut (
        .vga_clk      (vga_clk),
        .reset_n      (reset_n),
        .value_in     (value_in),
        .value_valid  (value_valid),
        .value_ready  (value_ready),
        .busy         (busy),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .digit_out    (digit_out),
        .glyph_x      (glyph_x),
        .glyph_y      (glyph_y),
        .digit_active (digit_active)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int p10(input int n);
        int r;
        r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    // ---------------- behavioural reference model ----------------
    // Displayed value kept as a plain integer; a pending conversion is a
    // countdown of VW cycles followed by a wait for DrawY >= 480.
    int         m_disp, m_val, m_cnt;
    bit         m_pend = 1'b0;
    bit         m_ok   = 1'b0;
    logic [3:0] e_dig;
    logic [5:0] e_gx, e_gy;
    logic       e_act;

    always @(posedge vga_clk) begin
        int rx, ry, i;
        if (!reset_n) begin
            m_disp = 0; m_val = 0; m_cnt = 0; m_pend = 1'b0; m_ok = 1'b1;
            e_dig = 4'd0; e_gx = 6'd0; e_gy = 6'd0; e_act = 1'b0;
        end else begin
            rx = int'(DrawX) - OX;
            ry = int'(DrawY) - OY;
            if (rx >= 0 && rx < ND*GW && ry >= 0 && ry < GH) begin
                i     = rx / GW;
                e_dig = 4'((m_disp / p10(ND-1-i)) % 10);
                e_gx  = 6'(rx - i*GW);
                e_gy  = 6'(ry);
                e_act = !(LZB && i < ND-1 && m_disp < p10(ND-1-i));
            end else begin
                e_dig = 4'd0; e_gx = 6'd0; e_gy = 6'd0; e_act = 1'b0;
            end
            if (!m_pend) begin
                if (value_valid) begin
                    m_pend = 1'b1;
                    m_cnt  = VW;
                    m_val  = (int'(value_in) > p10(ND)-1) ? p10(ND)-1 : int'(value_in);
                end
            end else if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
            end else if (DrawY >= 10'd480) begin
                m_disp = m_val;
                m_pend = 1'b0;
            end
        end
    end

    // Compare process: every cycle once the model has seen a reset edge.
    always @(negedge vga_clk) begin
        if (m_ok) begin
            chk("ready",  32'(value_ready),  32'(!m_pend));
            chk("busy",   32'(busy),         32'(m_pend));
            chk("digit",  32'(digit_out),    32'(e_dig));
            chk("gx",     32'(glyph_x),      32'(e_gx));
            chk("gy",     32'(glyph_y),      32'(e_gy));
            chk("active", 32'(digit_active), 32'(e_act));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_ready();
        int n;
        n = 0;
        while (value_ready !== 1'b1 && n < 200) begin
            @(negedge vga_clk);
            n++;
        end
        if (value_ready !== 1'b1) chk("ready_timeout", 32'(0), 32'(1));
    endtask

    task automatic pix(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(negedge vga_clk);
    endtask

    // Load a value with the raster in the active area, hold through PEND,
    // then give one vblank line so it commits.
    task automatic load(input int v, input bit inject);
        DrawX = 10'd0;
        DrawY = 10'd100;
        wait_ready();
        value_in    = VW'(v);
        value_valid = 1'b1;
        @(negedge vga_clk);
        value_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (inject && c >= 2 && c < 5) begin
                value_in    = VW'(5678);
                value_valid = 1'b1;
                chk("ignored_ready", 32'(value_ready), 32'(0));
            end else begin
                value_valid = 1'b0;
            end
            @(negedge vga_clk);
            chk("load_busy", 32'(busy), 32'(1));
        end
        value_valid = 1'b0;
        DrawY = 10'd480;
        @(negedge vga_clk);
        DrawY = 10'd100;
        @(negedge vga_clk);
        chk("load_committed", 32'(busy), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0; value_valid = 1'b0; value_in = '0;
        DrawX = 10'd0; DrawY = 10'd0;
        repeat (2) @(negedge vga_clk);
        chk("rst_ready", 32'(value_ready), 32'(1));
        chk("rst_busy",  32'(busy),        32'(0));
        reset_n = 1'b1;
        pix(OX, OY);
        chk("rst_pix_digit",  32'(digit_out),    32'(0));
        chk("rst_pix_active", 32'(digit_active), 32'(!LZB));

        // 1234 with a 5678 pulse during conversion; pre-commit pixel stays old.
        DrawY = 10'd100;
        wait_ready();
        value_in = VW'(1234); value_valid = 1'b1;
        @(negedge vga_clk);
        value_valid = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (c >= 2 && c < 5) begin
                value_in = VW'(5678); value_valid = 1'b1;
            end else begin
                value_valid = 1'b0;
            end
            chk("conv_busy",  32'(busy),        32'(1));
            chk("conv_ready", 32'(value_ready), 32'(0));
            @(negedge vga_clk);
        end
        value_valid = 1'b0;
        pix(OX + 93, OY + 5);
        pix(OX + 93, OY + 5);
        chk("pend_busy",      32'(busy),      32'(1));
        chk("pend_old_digit", 32'(digit_out), 32'(0));
        pix(0, 480);
        pix(OX + 93, OY + 5);
        chk("c1234_digit",  32'(digit_out),    32'(3));
        chk("c1234_gx",     32'(glyph_x),      32'(3));
        chk("c1234_gy",     32'(glyph_y),      32'(5));
        chk("c1234_active", 32'(digit_active), 32'(1));
        pix(OX + 1, OY);
        chk("c1234_msd", 32'(digit_out), 32'(1));

        load(12000, 1'b1);
        pix(OX + 1, OY);          chk("sat_msd", 32'(digit_out), 32'(9));
        pix(OX + 3*GW + 1, OY);   chk("sat_lsd", 32'(digit_out), 32'(9));
        load(9999, 1'b0);
        pix(OX + 3*GW + 1, OY);   chk("max_lsd", 32'(digit_out), 32'(9));
        load(0, 1'b0);
        pix(OX + 1, OY);
        chk("zero_msd",        32'(digit_out),    32'(0));
        chk("zero_msd_active", 32'(digit_active), 32'(!LZB));
        pix(OX + 3*GW + 1, OY);
        chk("zero_lsd_active", 32'(digit_active), 32'(1));
        load(42, 1'b0);
        pix(OX + GW + 1, OY);     chk("v42_d1_active", 32'(digit_active), 32'(!LZB));
        pix(OX + 2*GW + 1, OY);
        chk("v42_d2_active", 32'(digit_active), 32'(1));
        chk("v42_d2_digit",  32'(digit_out),    32'(4));

        // Region edges.
        pix(OX + ND*GW, OY);
        chk("edge_x_active", 32'(digit_active), 32'(0));
        chk("edge_x_gy",     32'(glyph_y),      32'(0));
        pix(OX, OY + GH);
        chk("edge_y_active", 32'(digit_active), 32'(0));
        chk("edge_y_digit",  32'(digit_out),    32'(0));
        pix(OX + ND*GW - 1, OY + GH - 1);
        chk("corner_gx", 32'(glyph_x), 32'(GW - 1));
        chk("corner_gy", 32'(glyph_y), 32'(GH - 1));

        // Randomized phase, including occasional mid-conversion resets.
        for (int c = 0; c < 4000; c++) begin
            reset_n     = ($urandom_range(0, 399) != 0);
            value_valid = ($urandom_range(0, 9) < 3);
            value_in    = VW'($urandom_range(0, (1 << VW) - 1));
            DrawX       = 10'($urandom_range(540, 760));
            if ($urandom_range(0, 9) < 2) DrawY = 10'($urandom_range(480, 524));
            else                          DrawY = 10'($urandom_range(0, 90));
            @(negedge vga_clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
